// File: rtl/demux_pkg.sv
// Shared constants for the 1x2 TDM demultiplexer: frame FSM encoding, default sizes, channel tags.
package demux_pkg;

  typedef logic [0:0] state_t;

  localparam state_t EXP_A = 1'b0;
  localparam state_t EXP_B = 1'b1;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefDepth = 2;
  localparam int unsigned DefCntW  = 8;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO; full is derived from registered occupancy, so a full FIFO
// refuses a push even when it pops on the same edge.
module demux_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    // Depth is a power of two, so natural pointer overflow is the modulo wrap.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/demux_1x2_tdm.sv
// 1x2 TDM demux: routes tagged beats into two FIFO channels, tracks A-then-B frames.
// Optional even-parity drop check enabled by macro DEMUX_PARITY_EN.
module demux_1x2_tdm
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef DEMUX_PARITY_EN
  input  logic             in_par,
  output logic             par_err,
`endif
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             seq_err,
  output logic [CNT_W-1:0] frame_cnt
);

  logic       full0, full1, empty0, empty1;
  logic       accept, route, par_bad;
  state_t     state_q, state_d;
  logic       seq_err_q, seq_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign in_ready = (in_sel == CH1) ? ~full1 : ~full0;
  assign accept   = in_valid & in_ready;

`ifdef DEMUX_PARITY_EN
  logic par_err_q;
  assign par_bad = ^{in_data, in_par};
  assign par_err = par_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err_q <= 1'b0;
    else        par_err_q <= accept & par_bad;
  end
`else
  assign par_bad = 1'b0;
`endif

  // Parity-failed beats are consumed but neither stored nor seen by the frame tracker.
  assign route = accept & ~par_bad;

  demux_fifo #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_fifo0 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (route & (in_sel == CH0)),
    .data_i  (in_data),
    .pop_i   (out0_ready),
    .full_o  (full0),
    .empty_o (empty0),
    .head_o  (out0_data)
  );

  demux_fifo #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_fifo1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (route & (in_sel == CH1)),
    .data_i  (in_data),
    .pop_i   (out1_ready),
    .full_o  (full1),
    .empty_o (empty1),
    .head_o  (out1_data)
  );

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    seq_err_d   = 1'b0;
    if (route) begin
      case (state_q)
        EXP_A: begin
          if (in_sel == CH0) state_d = EXP_B;
          else               seq_err_d = 1'b1;
        end
        EXP_B: begin
          // An extra channel-0 beat restarts the frame in place.
          if (in_sel == CH1) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = EXP_A;
          end else begin
            seq_err_d = 1'b1;
          end
        end
        default: state_d = EXP_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EXP_A;
      frame_cnt_q <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seq_err   = seq_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_demux_1x2_tdm.sv
// Directed self-checking bench for demux_1x2_tdm; parity cases build under DEMUX_PARITY_EN.
module tb_demux_1x2_tdm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_data;
  logic       in_sel, in_valid, in_ready;
  logic [3:0] out0_data, out1_data;
  logic       out0_valid, out0_ready, out1_valid, out1_ready;
  logic       seq_err;
  logic [7:0] frame_cnt;
  int         n_checks = 0;
  int         n_fail   = 0;

`ifdef DEMUX_PARITY_EN
  logic in_par, par_err;
  logic par_flip = 1'b0;
  assign in_par = (^in_data) ^ par_flip;
`endif

  always #5 clk = ~clk;

  demux_1x2_tdm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef DEMUX_PARITY_EN
    .in_par     (in_par),
    .par_err    (par_err),
`endif
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .seq_err    (seq_err),
    .frame_cnt  (frame_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic [3:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #3;
    rst_n    = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    #1;
    check_eq("rst_out0_valid", out0_valid, 0);
    check_eq("rst_out1_valid", out1_valid, 0);
    check_eq("rst_out0_data", out0_data, 0);
    check_eq("rst_frame_cnt", frame_cnt, 0);
    check_eq("rst_seq_err", seq_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Clean pairs 0/1 .. 6/7
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'(2 * i));
      tick();
      check_eq("pair_out0_valid", out0_valid, 1);
      check_eq("pair_out0_data", out0_data, 2 * i);
      check_eq("pair_seq_err", seq_err, 0);
      drive(1'b1, 4'(2 * i + 1));
      tick();
      check_eq("pair_out1_valid", out1_valid, 1);
      check_eq("pair_out1_data", out1_data, 2 * i + 1);
      check_eq("pair_out0_popped", out0_valid, 0);
    end
    in_valid = 1'b0;
    tick();
    check_eq("pair_out1_drained", out1_valid, 0);
    check_eq("pair_frame_cnt", frame_cnt, 4);

    // Channel 1 stalled; channel 0 keeps flowing
    out1_ready = 1'b0;
    drive(1'b1, 4'd9);
    #1 check_eq("stall_ready_9", in_ready, 1);
    tick();
    check_eq("stall_seq_err_9", seq_err, 1);
    check_eq("stall_head_9", out1_data, 9);
    drive(1'b1, 4'd10);
    tick();
    drive(1'b1, 4'd11);
    #1 check_eq("stall_full_ready", in_ready, 0);
    tick();
    check_eq("stall_head_still_9", out1_data, 9);
    drive(1'b0, 4'd5);
    #1 check_eq("stall_ch0_ready", in_ready, 1);
    tick();
    check_eq("stall_out0_valid", out0_valid, 1);
    check_eq("stall_out0_data", out0_data, 5);
    drive(1'b1, 4'd11);
    out1_ready = 1'b1;
    #1 check_eq("drain_ready_still_full", in_ready, 0);
    tick();
    check_eq("drain_head_10", out1_data, 10);
    check_eq("drain_ready_open", in_ready, 1);
    tick();
    check_eq("drain_head_11", out1_data, 11);
    check_eq("drain_valid_11", out1_valid, 1);
    in_valid = 1'b0;
    tick();
    check_eq("drain_empty", out1_valid, 0);
    check_eq("stall_frame_cnt", frame_cnt, 5);

    // sel 0,0,1 : second channel-0 beat is out of order
    do_reset();
    drive(1'b0, 4'd1);
    tick();
    check_eq("oo_seq_err_1", seq_err, 0);
    check_eq("oo_out0_1", out0_data, 1);
    drive(1'b0, 4'd2);
    tick();
    check_eq("oo_seq_err_2", seq_err, 1);
    check_eq("oo_out0_2", out0_data, 2);
    drive(1'b1, 4'd3);
    tick();
    check_eq("oo_seq_err_3", seq_err, 0);
    check_eq("oo_out1_3", out1_data, 3);
    check_eq("oo_frame_cnt", frame_cnt, 1);
    in_valid = 1'b0;
    tick();
    check_eq("oo_seq_err_clear", seq_err, 0);

    // Channel-1 beat first: error, still routed, FSM stays in EXP_A
    do_reset();
    drive(1'b1, 4'd8);
    tick();
    check_eq("b_first_seq_err", seq_err, 1);
    check_eq("b_first_out1_valid", out1_valid, 1);
    check_eq("b_first_out1_data", out1_data, 8);
    check_eq("b_first_frame_cnt", frame_cnt, 0);
    drive(1'b0, 4'd6);
    tick();
    check_eq("b_first_fsm_exp_a", seq_err, 0);
    drive(1'b1, 4'd7);
    tick();
    check_eq("b_first_frame_after", frame_cnt, 1);
    in_valid = 1'b0;

    // 256 frames wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 4'(i));
      tick();
      drive(1'b1, 4'(i + 1));
      tick();
      if (i == 254) check_eq("wrap_cnt_255", frame_cnt, 255);
    end
    in_valid = 1'b0;
    tick();
    check_eq("wrap_cnt_0", frame_cnt, 0);

    // Asynchronous reset with both FIFOs occupied
    out0_ready = 1'b0; out1_ready = 1'b0;
    drive(1'b0, 4'd3);
    tick();
    drive(1'b1, 4'd4);
    tick();
    in_valid = 1'b0;
    check_eq("pre_rst_out0_valid", out0_valid, 1);
    check_eq("pre_rst_out1_valid", out1_valid, 1);
    check_eq("pre_rst_frame_cnt", frame_cnt, 1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_rst_out0_valid", out0_valid, 0);
    check_eq("async_rst_out1_valid", out1_valid, 0);
    check_eq("async_rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();

`ifdef DEMUX_PARITY_EN
    par_flip = 1'b1;
    drive(1'b0, 4'b0011);
    tick();
    check_eq("par_bad_err", par_err, 1);
    check_eq("par_bad_no_out0", out0_valid, 0);
    check_eq("par_bad_frame_cnt", frame_cnt, 0);
    par_flip = 1'b0;
    drive(1'b0, 4'b0011);
    tick();
    check_eq("par_ok_err", par_err, 0);
    check_eq("par_ok_out0_valid", out0_valid, 1);
    check_eq("par_ok_out0_data", out0_data, 3);
    in_valid = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x2_tdm.md
Name: demux_1x2_tdm

Overview:
Receive-side counterpart of the 2x1 4-bit mux. It accepts a time-multiplexed stream of beats, each tagged with a channel select, and routes every beat to one of two output channels. Each output channel has its own small FIFO and a valid/ready handshake. The block also tracks A-then-B frame pairing, flags out-of-order selects and counts completed frames.

Parameters:
WIDTH, 4, data width of each beat and each output channel
DEPTH, 2, entries per channel FIFO; power of 2, at least 2
CNT_W, 8, width of frame counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_data  in  WIDTH  multiplexed beat
in_sel  in  1  channel tag: 0 -> channel 0, 1 -> channel 1
in_valid  in  1  beat present
in_ready  out  1  beat can be accepted
out0_data  out  WIDTH  channel 0 FIFO head
out0_valid  out  1  channel 0 not empty
out0_ready  in  1  channel 0 consumer takes head
out1_data  out  WIDTH  channel 1 FIFO head
out1_valid  out  1  channel 1 not empty
out1_ready  in  1  channel 1 consumer takes head
seq_err  out  1  one-cycle pulse: accepted beat's select differs from the expected one
frame_cnt  out  CNT_W  completed frames (channel-0 beat followed by channel-1 beat)

Behaviour:
- Reset (asynchronous, active-low): both FIFOs empty; out*_valid=0; out*_data=0; seq_err=0; frame_cnt=0; FSM in EXP_A.
- Handshake rules:
  - in_ready is combinational: not full of the FIFO selected by in_sel. It depends only on in_sel and full flags, never on in_valid.
  - A beat is accepted on a rising edge when in_valid && in_ready.
  - Pop of channel k on a rising edge when outk_valid && outk_ready.
- Latency: a beat accepted at edge N appears on outk_data/outk_valid immediately after edge N. There is no same-cycle bypass.
- Full boundary: a FIFO that is full at edge N refuses a push, even if it pops at the same edge (registered full only).
- Simultaneous push/pop on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
- Empty boundary: outk_valid=0 and outk_data holds its last value, don't-care for checking.
- Pointers wrap modulo DEPTH. Occupancy counters are clog2(DEPTH)+1 bits wide.
- Channel isolation: a stalled channel (outk_ready=0) never blocks beats for the other channel.
- FSM, states EXP_A and EXP_B, advancing only on accepted beats:
  - EXP_A, sel=0 -> EXP_B.
  - EXP_A, sel=1 -> seq_err pulse; stay in EXP_A.
  - EXP_B, sel=1 -> frame_cnt+1; -> EXP_A.
  - EXP_B, sel=0 -> seq_err pulse; stay in EXP_B, so the newest channel-0 beat starts the frame.
  - Beats that trigger seq_err are still routed normally.
- seq_err is registered: high for exactly the cycle after the offending accept.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-operation: all FIFO contents discarded and the above reset values applied immediately. No beat is accepted while rst_n=0.

Optional Feature:
Macro DEMUX_PARITY_EN.
- Defined:
  - Adds port in_par (in, 1), an even-parity bit over in_data.
  - Adds port par_err (out, 1), a registered one-cycle pulse.
  - An accepted beat whose XOR of in_data and in_par is 1 is dropped: not pushed, FSM and frame_cnt unchanged, par_err pulses.
  - in_ready is unaffected by parity.
- Not defined: neither port exists and every accepted beat is routed.

Decomposition:
- Package demux_pkg:
  - state enum (EXP_A, EXP_B)
  - default WIDTH=4, DEPTH=2, CNT_W=8 constants
  - channel index constants CH0=0, CH1=1
- Sub-module demux_fifo: synchronous FIFO of WIDTH x DEPTH with push/pop/full/empty/head ports, instantiated twice.
- Top level holds routing, FSM, counter and optional parity check.

Test Plan:
- Pairs Ia/Ib = 0/1, 2/3, 4/5, 6/7 sent as sel=0 then sel=1, both ready=1 -> out0 sequence 0,2,4,6; out1 sequence 1,3,5,7; each one cycle after accept; frame_cnt=4; seq_err never high.
- out1_ready=0, send sel=1 beats 9,10,11 -> first two accepted; in_ready=0 for the third while sel=1. A sel=0 beat 5 is accepted and appears on out0. Raising out1_ready drains 9,10, then 11 is accepted.
- Sequence sel=0,0,1 with data 1,2,3 -> seq_err pulses once after the second beat; frame_cnt=1; out0 sequence 1,2.
- Sequence sel=1 first, data 8 -> seq_err pulse; routed to out1; FSM still EXP_A; frame_cnt=0.
- 256 clean frames -> frame_cnt wraps to 0. Assert rst_n=0 with both FIFOs holding data -> out0_valid=0, out1_valid=0, frame_cnt=0 immediately, without waiting for a clock edge.
- With DEMUX_PARITY_EN: in_data=4'b0011, in_par=1 -> dropped, par_err pulse, no out valid. in_par=0 -> routed normally.
